// File: rtl/mbssoc_bus_pkg.sv
// mbssoc_bus_pkg: shared constants and types for the two-core bus arbiter.
//   ADDR_WIDTH / RAM_TOP : default bus width and top of the RAM region
//   APIC_*_ADDR          : word addresses of the APIC write-only registers
//   bus_state_e          : arbiter FSM encoding
//   bus_ctl_t            : per-transaction control latched when a core wins
package mbssoc_bus_pkg;

  localparam int          ADDR_WIDTH        = 32;
  localparam logic [31:0] RAM_TOP           = 32'h0200_0000;
  localparam logic [31:0] APIC_CONF_ADDR    = 32'h0300_0000;
  localparam logic [31:0] APIC_CPU0_PC_ADDR = 32'h0300_0004;
  localparam logic [31:0] APIC_CPU1_PC_ADDR = 32'h0300_0008;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic win;  // winning core index
    logic we;   // write (1) / read (0)
    logic lk;   // LL on read, SC on write
  } bus_ctl_t;

endpackage

// File: rtl/mbssoc_rr_arb2.sv
// mbssoc_rr_arb2: two-way round-robin pick.
//   req[1:0] : request vector
//   ptr      : core that wins a tie
//   gnt[1:0] : one-hot grant (zero when nothing is requested)
module mbssoc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mbssoc_bus_arbiter.sv
// mbssoc_bus_arbiter: serialises two cores onto one RAM port plus three APIC
// write strobes, and keeps a single LL/SC reservation.
//   clk, rst_n          : clock, async active-low reset
//   req/we/lk[1:0]      : per-core request, write, LL/SC qualifier
//   addr0, addr1        : per-core address
//   ram_ack             : RAM access complete (only looked at in ACCESS)
//   pause, done, sc_fail: per-core stall, completion pulse, SC failure flag
//   ram_re/ram_we/addr  : RAM port
//   apic_*              : one-cycle APIC write strobes
//   lock_addr           : reservation address, all-ones when none held
module mbssoc_bus_arbiter #(
  parameter int          ADDR_WIDTH = mbssoc_bus_pkg::ADDR_WIDTH,
  parameter logic [31:0] RAM_TOP    = mbssoc_bus_pkg::RAM_TOP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            lk,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  ram_ack,
  output logic [1:0]            pause,
  output logic [1:0]            done,
  output logic [1:0]            sc_fail,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  apic_conf,
  output logic                  apic_cpu0_pc,
  output logic                  apic_cpu1_pc,
  output logic [ADDR_WIDTH-1:0] lock_addr
);
  import mbssoc_bus_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] RAM_TOP_A = ADDR_WIDTH'(RAM_TOP);
  localparam logic [ADDR_WIDTH-1:0] CONF_A    = ADDR_WIDTH'(APIC_CONF_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PC0_A     = ADDR_WIDTH'(APIC_CPU0_PC_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PC1_A     = ADDR_WIDTH'(APIC_CPU1_PC_ADDR);

  bus_state_e            state_q, state_d;
  bus_ctl_t              ctl_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ptr_q;
  logic                  fail_q;
  logic                  rsv_vld_q, rsv_own_q;
  logic [ADDR_WIDTH-1:0] rsv_addr_q;

  logic [1:0] gnt;
  logic       in_acc, is_ram, sc_ok, sc_blk, ram_go, wr_go, acc_end;

  mbssoc_rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Decode of the latched transaction.
  assign in_acc = (state_q == ST_ACCESS);
  assign is_ram = (addr_q < RAM_TOP_A);
  assign sc_ok  = rsv_vld_q && (rsv_own_q == ctl_q.win) && (rsv_addr_q == addr_q);
  // A failing SC behaves as a one-cycle no-op.
  assign sc_blk = ctl_q.we & ctl_q.lk & ~sc_ok;
  assign ram_go = in_acc & is_ram & ~sc_blk;
  assign wr_go  = in_acc & ctl_q.we & ~sc_blk;
  // RAM waits for ack; everything else (incl. blocked SC) takes one cycle.
  assign acc_end = in_acc & (~ram_go | ram_ack);

  assign ram_re       = ram_go & ~ctl_q.we;
  assign ram_we       = ram_go & ctl_q.we;
  assign ram_addr     = ram_go ? addr_q : '0;
  assign apic_conf    = wr_go & (addr_q == CONF_A);
  assign apic_cpu0_pc = wr_go & (addr_q == PC0_A);
  assign apic_cpu1_pc = wr_go & (addr_q == PC1_A);

  assign done      = (state_q == ST_DONE) ? (ctl_q.win ? 2'b10 : 2'b01) : 2'b00;
  assign sc_fail   = fail_q ? done : 2'b00;
  // Gated by rst_n so the stall also reads low while reset is held.
  assign pause     = req & ~done & {2{rst_n}};
  assign lock_addr = rsv_vld_q ? rsv_addr_q : '1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|req)   state_d = ST_ACCESS;
      ST_ACCESS: if (acc_end) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctl_q      <= '0;
      addr_q     <= '0;
      ptr_q      <= 1'b0;
      fail_q     <= 1'b0;
      rsv_vld_q  <= 1'b0;
      rsv_own_q  <= 1'b0;
      rsv_addr_q <= '1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && |req) begin
        ctl_q.win <= gnt[1];
        ctl_q.we  <= we[gnt[1]];
        ctl_q.lk  <= lk[gnt[1]];
        addr_q    <= gnt[1] ? addr1 : addr0;
      end
      if (state_q == ST_DONE) ptr_q <= ~ctl_q.win;
      // Reservation moves only when an access completes.
      if (acc_end) begin
        fail_q <= sc_blk;
        if (!ctl_q.we && ctl_q.lk) begin
          rsv_vld_q  <= 1'b1;
          rsv_addr_q <= addr_q;
          rsv_own_q  <= ctl_q.win;
        end else if (ctl_q.we && ctl_q.lk) begin
          if (sc_ok) rsv_vld_q <= 1'b0;
        end else if (ctl_q.we && addr_q == rsv_addr_q) begin
          rsv_vld_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbssoc_bus_arbiter.sv
module tb_mbssoc_bus_arbiter;
  import mbssoc_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = '0, we = '0, lk = '0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic        ram_ack = 1'b0;
  logic [1:0]  pause, done, sc_fail;
  logic        ram_re, ram_we, apic_conf, apic_cpu0_pc, apic_cpu1_pc;
  logic [31:0] ram_addr, lock_addr;

  int checks = 0;
  int errors = 0;

  mbssoc_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lk(lk),
    .addr0(addr0), .addr1(addr1), .ram_ack(ram_ack),
    .pause(pause), .done(done), .sc_fail(sc_fail),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .apic_conf(apic_conf), .apic_cpu0_pc(apic_cpu0_pc), .apic_cpu1_pc(apic_cpu1_pc),
    .lock_addr(lock_addr)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level reference model ----------------
  bit          m_busy = 0, m_ph = 0, m_we = 0, m_lk = 0, m_fail = 0, m_ptr = 0;
  int          m_win = 0;
  logic [31:0] m_addr = '0;
  bit          r_v = 0;
  int          r_own = 0;
  logic [31:0] r_a = '0;

  function automatic bit sc_ok_f();
    return r_v && (r_own == m_win) && (r_a == m_addr);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_ph = 0; m_ptr = 0; r_v = 0; m_fail = 0;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        m_win  = (req == 2'b11) ? int'(m_ptr) : (req[1] ? 1 : 0);
        m_addr = (m_win == 1) ? addr1 : addr0;
        m_we   = we[m_win];
        m_lk   = lk[m_win];
        m_busy = 1; m_ph = 0;
      end
    end else if (!m_ph) begin
      bit ok, blk, ram;
      ok  = sc_ok_f();
      blk = m_we && m_lk && !ok;
      ram = m_addr < RAM_TOP;
      if (!ram || blk || ram_ack) begin
        if (!m_we && m_lk) begin r_v = 1; r_a = m_addr; r_own = m_win; end
        else if (m_we && m_lk) begin if (ok) r_v = 0; end
        else if (m_we && r_v && m_addr == r_a) r_v = 0;
        m_fail = blk;
        m_ph = 1;
      end
    end else begin
      m_busy = 0;
      m_ptr  = (m_win == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0]  last_done = '0;
  logic [74:0] got, expv;
  logic [1:0]  e_done, e_fail, e_pause;
  logic        e_re, e_we, e_c, e_p0, e_p1, acc, blk, ram, wr;
  logic [31:0] e_ra, e_lock;

  initial forever begin
    @(negedge clk);
    e_done  = (m_busy && m_ph) ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_fail  = m_fail ? e_done : 2'b00;
    acc     = m_busy && !m_ph;
    blk     = m_we && m_lk && !sc_ok_f();
    ram     = m_addr < RAM_TOP;
    e_re    = acc && ram && !blk && !m_we;
    e_we    = acc && ram && !blk && m_we;
    e_ra    = (e_re || e_we) ? m_addr : 32'h0;
    wr      = acc && m_we && !blk;
    e_c     = wr && (m_addr == APIC_CONF_ADDR);
    e_p0    = wr && (m_addr == APIC_CPU0_PC_ADDR);
    e_p1    = wr && (m_addr == APIC_CPU1_PC_ADDR);
    e_pause = rst_n ? (req & ~e_done) : 2'b00;
    e_lock  = r_v ? r_a : 32'hFFFF_FFFF;
    got  = {pause, done, sc_fail, ram_re, ram_we, ram_addr, apic_conf, apic_cpu0_pc, apic_cpu1_pc, lock_addr};
    expv = {e_pause, e_done, e_fail, e_re, e_we, e_ra, e_c, e_p0, e_p1, e_lock};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, got, expv);
    end
    last_done = done;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  // One uncontested transaction; counts cycles relative to req rising.
  task automatic xact(input int c, input logic [31:0] a, input logic w, input logic l,
                      input int dly, output int dcyc, output int n_re, output int n_we,
                      output int n_apic, output logic f);
    dcyc = -1; n_re = 0; n_we = 0; n_apic = 0; f = 1'b0;
    req[c] = 1'b1; we[c] = w; lk[c] = l;
    if (c == 0) addr0 = a; else addr1 = a;
    for (int k = 0; k < 40; k++) begin
      ram_ack = (k >= 1 + dly);
      @(negedge clk);
      n_re   += int'(ram_re);
      n_we   += int'(ram_we);
      n_apic += 100 * int'(apic_conf) + 10 * int'(apic_cpu0_pc) + int'(apic_cpu1_pc);
      if (done[c]) begin dcyc = k; f = sc_fail[c]; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[c] = 1'b0; ram_ack = 1'b0;
  endtask

  logic [31:0] tbl [8];
  int          hold [2];
  int          dc, nre, nwe, nap, ndone;
  logic        fl;
  logic [31:0] ra;
  bit          stop;

  initial begin
    tbl = '{32'h40, 32'h40, 32'h44, 32'h100, RAM_TOP,
            APIC_CONF_ADDR, APIC_CPU0_PC_ADDR, APIC_CPU1_PC_ADDR};
    #2 rst_n = 1'b0;
    repeat (2) next();
    // reset state, pause forced low while reset held
    req = 2'b11; #1;
    chk("rst_pause", 32'(pause), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ram_re", 32'(ram_re), 32'h0);
    chk("rst_lock", lock_addr, 32'hFFFF_FFFF);
    req = 2'b00;
    next(); rst_n = 1'b1;
    next();

    // both cores contend, reads to 0x100, ack immediate
    req = 2'b11; addr0 = 32'h100; addr1 = 32'h100; we = 2'b00; lk = 2'b00; ram_ack = 1'b1;
    @(negedge clk); chk("c0_pause", 32'(pause), 32'h3); chk("c0_done", 32'(done), 32'h0);
    next(); @(negedge clk); chk("c1_ram_re", 32'(ram_re), 32'h1); chk("c1_addr", ram_addr, 32'h100);
    next(); @(negedge clk); chk("c2_done", 32'(done), 32'h1); chk("c2_pause", 32'(pause), 32'h2);
    next(); req[0] = 1'b0;
    @(negedge clk); chk("c3_done", 32'(done), 32'h0); chk("c3_pause", 32'(pause), 32'h2);
    next(); @(negedge clk); chk("c4_ram_re", 32'(ram_re), 32'h1); chk("c4_pause", 32'(pause), 32'h2);
    next(); @(negedge clk); chk("c5_done", 32'(done), 32'h2); chk("c5_pause", 32'(pause), 32'h0);
    next(); req = 2'b00; ram_ack = 1'b0;
    next();

    // LL then successful SC
    xact(0, 32'h40, 1'b0, 1'b1, 0, dc, nre, nwe, nap, fl);
    chk("ll_lock", lock_addr, 32'h40);
    xact(0, 32'h40, 1'b1, 1'b1, 0, dc, nre, nwe, nap, fl);
    chk("sc_ok_we", 32'(nwe), 32'd1); chk("sc_ok_fail", 32'(fl), 32'h0);
    chk("sc_ok_lock", lock_addr, 32'hFFFF_FFFF); chk("sc_ok_lat", 32'(dc), 32'd2);

    // LL, foreign plain write kills reservation, SC fails
    xact(0, 32'h40, 1'b0, 1'b1, 0, dc, nre, nwe, nap, fl);
    xact(1, 32'h40, 1'b1, 1'b0, 0, dc, nre, nwe, nap, fl);
    chk("kill_we", 32'(nwe), 32'd1); chk("kill_lock", lock_addr, 32'hFFFF_FFFF);
    xact(0, 32'h40, 1'b1, 1'b1, 0, dc, nre, nwe, nap, fl);
    chk("sc_bad_we", 32'(nwe), 32'd0); chk("sc_bad_fail", 32'(fl), 32'h1);
    chk("sc_bad_lat", 32'(dc), 32'd2);

    // APIC write strobe
    xact(1, APIC_CPU1_PC_ADDR, 1'b1, 1'b0, 0, dc, nre, nwe, nap, fl);
    chk("apic_strobes", 32'(nap), 32'd1); chk("apic_we", 32'(nwe), 32'd0);
    chk("apic_lat", 32'(dc), 32'd2);

    // delayed ack
    xact(0, 32'h100, 1'b0, 1'b0, 3, dc, nre, nwe, nap, fl);
    chk("dly_re", 32'(nre), 32'd4); chk("dly_lat", 32'(dc), 32'd5);

    // unmapped read
    xact(0, RAM_TOP, 1'b0, 1'b0, 0, dc, nre, nwe, nap, fl);
    chk("unmap_en", 32'(nre + nwe + nap), 32'd0); chk("unmap_lat", 32'(dc), 32'd2);

    // reset in the middle of a RAM wait, with a reservation held
    xact(1, 32'h80, 1'b0, 1'b1, 0, dc, nre, nwe, nap, fl);
    chk("ll1_lock", lock_addr, 32'h80);
    req[0] = 1'b1; addr0 = 32'h100; we[0] = 1'b0; lk[0] = 1'b0; ram_ack = 1'b0;
    next(); next(); #2;
    chk("abort_re_pre", 32'(ram_re), 32'h1);
    rst_n = 1'b0; #1;
    chk("abort_re_async", 32'(ram_re), 32'h0);
    chk("abort_lock", lock_addr, 32'hFFFF_FFFF);
    chk("abort_pause", 32'(pause), 32'h0);
    req = 2'b00;
    next(); next(); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); ndone += int'(|done); end
    chk("abort_no_done", 32'(ndone), 32'd0);
    next();

    // randomized traffic, drop req on the done edge
    hold[0] = 0; hold[1] = 0;
    for (int n = 0; n < 3200; n++) begin
      next();
      stop = (n >= 3000);
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (last_done[i]) begin req[i] = 1'b0; hold[i] = 0; end
          else begin
            hold[i]++;
            if (hold[i] == 100) begin
              checks++; errors++;
              $display("FAIL rnd_timeout core%0d: got no done after %0d cycles, expected done", i, hold[i]);
            end
          end
        end else if (!stop && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          we[i]  = 1'($urandom_range(0, 1));
          lk[i]  = ($urandom_range(0, 2) == 0);
          ra     = tbl[$urandom_range(0, 7)];
          if (i == 0) addr0 = ra; else addr1 = ra;
        end
      end
      ram_ack = ($urandom_range(0, 2) == 0);
      if (stop && req == 2'b00) break;
    end
    chk("drain", 32'(req), 32'h0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
